mult_share_sched: RTL and testbench
===================================

Name: mult_share_sched

Overview:
- Round-robin scheduler that shares one 4x4 signed multiplier core (mult4s_normal_ripple, combinational, 8-bit two's-complement product) between NREQ requesters.
- Each requester presents an operand pair over a valid/ready handshake.
- The block arbitrates, registers the operands, drives the shared core, registers the product and returns it tagged with the requester index over a single valid/ready response channel with full backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must equal clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  4*NREQ  multiplicands, requester i at [4i+3:4i], signed.
- req_b  in  4*NREQ  multipliers, same packing, signed.
- resp_valid  out  1  product valid.
- resp_ready  in  1  consumer accept.
- resp_product  out  8  signed product a*b.
- resp_id  out  IDW  index of originating requester.
- busy  out  1  high while any pipeline stage holds data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - rst_n=0 at a rising edge clears s1_valid, s2_valid and rr_ptr to 0.
  - Reset also clears the stored data registers.
  - Outputs after reset: req_ready=0 for the cycle in reset, resp_valid=0, resp_product=0, resp_id=0, busy=0.
- Pipeline, two register stages:
  - S1 holds a_q, b_q, id_q, s1_valid. The core is fed from S1.
  - S2 holds product, id and s2_valid, and drives the resp_* ports directly.
- Advance rules:
  - s2_free = !s2_valid | resp_ready.
  - S1 moves to S2 when s1_valid & s2_free.
  - s1_free = !s1_valid | (s1_valid & s2_free).
- Arbitration (combinational):
  - When s1_free and rst_n=1, grant the first i with req_valid[i], scanning from rr_ptr upward modulo NREQ.
  - req_ready[g]=1 for the granted index only; all other req_ready bits are 0.
  - req_ready does not depend on req_valid of the same requester beyond selection.
- Handshake:
  - A transfer happens when req_valid[g] & req_ready[g]. S1 loads req_a/req_b slice g and id g.
  - rr_ptr becomes (g+1) mod NREQ only on a transfer; otherwise it holds.
- Latency and throughput:
  - Request accepted at edge t gives resp_valid=1 after edge t+1 with no backpressure, i.e. 2 cycles request-to-response.
  - Throughput is 1 per cycle with resp_ready held high.
- Backpressure:
  - While resp_valid=1 & resp_ready=0, resp_product and resp_id are stable.
  - S1 is held, and req_ready is all-zero when S1 is occupied.
  - No data is dropped or duplicated.
- Simultaneous events:
  - A response transfer and an S1->S2 move in the same cycle are legal; S2 reloads.
  - An S1 load and an S1 move in the same cycle are legal; S1 reloads.
- Arithmetic:
  - resp_product is the exact 8-bit two's-complement product. The range [-56, 64] fits without overflow.
  - The core output is used unmodified.
- busy = s1_valid | s2_valid.
- Reset mid-operation: in-flight entries are discarded with no response emitted, and rr_ptr returns to 0.
- Requesters must hold req_valid and operands until accepted; behaviour under withdrawal is unspecified but must not corrupt stored entries.

Decomposition:
- Shared package mult_sched_pkg holds:
  - localparams OPW=4 and PRODW=8;
  - the function rr_pick(valid_vec, ptr) returning the grant index and a found flag.
- One sub-module: mult_rr_arbiter (NREQ, IDW), with the pure combinational round-robin grant plus the rr_ptr register and its update-on-transfer rule.
- Multiplier core instantiated once at top level.

Test Plan:
1. Single requester 0 sends a=3, b=5 with resp_ready=1. Required: resp_valid exactly 2 cycles after acceptance, resp_product=0x0F, resp_id=0, busy then drops to 0.
2. Signed corners, back-to-back from requester 1: (-8,-8), (7,-8), (-1,-1), (-8,7). Required: products 0x40, 0xC8, 0x01, 0xC8 in order, one per cycle, all with resp_id=1.
3. All 4 requesters valid continuously with distinct operands. Required: grants in order 0,1,2,3,0,..., and each id's products are correct.
4. Backpressure: hold resp_ready=0 for 5 cycles after two accepts. Required:
   - resp_product/resp_id stable;
   - req_ready all 0 after S1 fills;
   - on release, both results emerge in order with no loss.
5. Reset mid-flight: assert rst_n=0 for 1 cycle with S1 and S2 full. Required:
   - resp_valid=0 and busy=0 the next cycle;
   - no stale response afterwards;
   - next grant starts at requester 0.
6. Sparse requests: only requesters 2 and 0 valid with rr_ptr=3. Required: grant 0 first, then 2; rr_ptr is unchanged on idle cycles.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared widths and round-robin pick helper for the multiplier scheduler
package mult_sched_pkg;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Scans up to 8 requesters starting at ptr, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [7:0] valid_vec, input logic [2:0] ptr,
                                      input int nreq);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            j = (int'(ptr) + k) % nreq;
            if (k < nreq && !r.found && valid_vec[3'(j)]) begin
                r.found = 1'b1;
                r.idx   = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult4s_normal_ripple.sv
// rtl/mult4s_normal_ripple.sv - combinational 4x4 signed multiplier, 8-bit product
module mult4s_normal_ripple
    import mult_sched_pkg::*;
(
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] product
);

    logic [PRODW-1:0] a_ext;
    logic [PRODW-1:0] b_ext;
    logic [PRODW-1:0] acc;

    // Sign-extended shift-and-add; modulo-256 sum is the exact signed product.
    always_comb begin
        a_ext = {{(PRODW-OPW){a[OPW-1]}}, a};
        b_ext = {{(PRODW-OPW){b[OPW-1]}}, b};
        acc   = '0;
        for (int i = 0; i < PRODW; i++) begin
            if (b_ext[i]) begin
                acc = acc + (a_ext << i);
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/mult_rr_arbiter.sv
// rtl/mult_rr_arbiter.sv - round-robin grant with pointer advanced on transfer
module mult_rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            s1_free,
    output logic [NREQ-1:0] req_ready,
    output logic [IDW-1:0]  grant,
    output logic            transfer
);

    logic [IDW-1:0] rr_ptr;
    pick_t          pick;

    always_comb begin
        pick = rr_pick(8'(req_valid), 3'(rr_ptr), NREQ);
    end

    assign grant     = IDW'(pick.idx);
    assign req_ready = (rst_n && s1_free && pick.found) ? (NREQ'(1) << grant) : '0;
    assign transfer  = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - two-stage pipeline sharing one signed multiplier among NREQ requesters
module mult_share_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [PRODW-1:0]    resp_product,
    output logic [IDW-1:0]      resp_id,
    output logic                busy
);

    logic [OPW-1:0]   a_q, b_q, sel_a, sel_b;
    logic [IDW-1:0]   id_q, grant;
    logic             s1_valid, s2_valid;
    logic [PRODW-1:0] core_product;
    logic             s2_free, s1_move, s1_free, transfer;

    assign s2_free = !s2_valid || resp_ready;
    assign s1_move = s1_valid && s2_free;
    assign s1_free = !s1_valid || s1_move;

    mult_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .s1_free   (s1_free),
        .req_ready (req_ready),
        .grant     (grant),
        .transfer  (transfer)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant) begin
                sel_a = req_a[i*OPW +: OPW];
                sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    mult4s_normal_ripple u_core (
        .a       (a_q),
        .b       (b_q),
        .product (core_product)
    );

    // A load takes priority over the drain so S1 can reload in the cycle it moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
        end else if (transfer) begin
            s1_valid <= 1'b1;
            a_q      <= sel_a;
            b_q      <= sel_b;
            id_q     <= grant;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            resp_product <= '0;
            resp_id      <= '0;
        end else if (s1_move) begin
            s2_valid     <= 1'b1;
            resp_product <= core_product;
            resp_id      <= id_q;
        end else if (resp_ready) begin
            s2_valid     <= 1'b0;
        end
    end

    assign resp_valid = s2_valid;
    assign busy       = s1_valid || s2_valid;

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - self-checking bench for mult_share_sched
module tb_mult_share_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_product;
    logic [1:0]  resp_id;
    logic        busy;

    always #5 clk = ~clk;

    mult_share_sched #(.NREQ(4), .IDW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id),
        .busy         (busy)
    );

    typedef struct {
        logic [7:0] p;
        logic [1:0] id;
        int         age;
    } ent_t;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_p;
    } vec_t;

    ent_t       m_q[$];
    int         m_rr;
    logic [3:0] acc_mask;
    int         grant_log[$];
    logic [7:0] got_p[$];
    logic [1:0] got_id[$];
    int         n_vec = 0;
    int         n_err = 0;
    vec_t       tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int pa;
        int pb;
        pa = $signed(a);
        pb = $signed(b);
        return 8'(pa * pb);
    endfunction

    // Model: capacity-2 in-order queue; head visible once it has aged one edge.
    task automatic check_cycle();
        int         g;
        int         j;
        logic [3:0] er;
        logic       erv;
        ent_t       e;
        g  = -1;
        er = '0;
        if (rst_n && (m_q.size() < 2 || resp_ready)) begin
            for (int k = 0; k < 4; k++) begin
                j = (m_rr + k) % 4;
                if (g < 0 && req_valid[2'(j)]) g = j;
            end
        end
        if (g >= 0) er[2'(g)] = 1'b1;
        erv = (m_q.size() >= 2) || (m_q.size() == 1 && m_q[0].age >= 1);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("resp_valid", 32'(resp_valid), 32'(erv));
        chk("busy", 32'(busy), 32'(m_q.size() != 0));
        if (erv) begin
            chk("resp_product", 32'(resp_product), 32'(m_q[0].p));
            chk("resp_id", 32'(resp_id), 32'(m_q[0].id));
        end
        if (resp_valid && resp_ready && rst_n) begin
            got_p.push_back(resp_product);
            got_id.push_back(resp_id);
        end
        acc_mask = req_valid & er;
        if (!rst_n) begin
            m_q.delete();
            m_rr = 0;
        end else begin
            if (erv && resp_ready) void'(m_q.pop_front());
            for (int k = 0; k < m_q.size(); k++) m_q[k].age = m_q[k].age + 1;
            if (g >= 0) begin
                e.p   = ref_mul(req_a[4*g +: 4], req_b[4*g +: 4]);
                e.id  = 2'(g);
                e.age = 0;
                m_q.push_back(e);
                m_rr = (g + 1) % 4;
                grant_log.push_back(g);
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        req_valid[2'(i)] = 1'b1;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    task automatic drain();
        for (int w = 0; w < 40 && (m_q.size() != 0 || req_valid != 0); w++) run_cycle();
        chk("drain_timeout", 32'(m_q.size() != 0 || req_valid != 0), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
    endtask

    task automatic rearm_all(input int k);
        for (int i = 0; i < 4; i++)
            if (!req_valid[2'(i)]) set_req(i, 4'(i + k), 4'(3 - i - k));
    endtask

    initial begin
        tv[0] = '{0, 4'd3, 4'd5, 8'h0F};
        tv[1] = '{1, 4'h8, 4'h8, 8'h40};
        tv[2] = '{1, 4'h7, 4'h8, 8'hC8};
        tv[3] = '{1, 4'hF, 4'hF, 8'h01};
        tv[4] = '{1, 4'h8, 4'h7, 8'hC8};
        tv[5] = '{2, 4'h7, 4'h7, 8'h31};
        tv[6] = '{3, 4'h0, 4'hB, 8'h00};
        tv[7] = '{0, 4'hD, 4'h4, 8'hF4};
        tv[8] = '{2, 4'h5, 4'hF, 8'hFB};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
        m_rr = 0; acc_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_resp_product", 32'(resp_product), 32'(0));
        chk("rst_resp_id", 32'(resp_id), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;

        // Single request, signed corners back-to-back, mixed requesters
        got_p.delete(); got_id.delete();
        for (int k = 0; k < 9; k++) begin
            set_req(tv[k].id, tv[k].a, tv[k].b);
            for (int w = 0; w < 10 && req_valid[2'(tv[k].id)]; w++) run_cycle();
            chk("accept_timeout", 32'(req_valid[2'(tv[k].id)]), 32'(0));
        end
        drain();
        chk("table_count", 32'(got_p.size()), 32'(9));
        for (int k = 0; k < 9 && k < got_p.size(); k++) begin
            chk("table_product", 32'(got_p[k]), 32'(tv[k].exp_p));
            chk("table_id", 32'(got_id[k]), 32'(tv[k].id));
        end

        // All requesters continuously valid: strict rotation from 0
        do_reset();
        grant_log.delete();
        for (int k = 0; k < 12; k++) begin
            rearm_all(k);
            run_cycle();
        end
        req_valid = '0;
        drain();
        chk("rotation_count", 32'(grant_log.size()), 32'(12));
        for (int k = 0; k < 12 && k < grant_log.size(); k++)
            chk("rotation_grant", 32'(grant_log[k]), 32'(k % 4));

        // Backpressure with both stages full
        do_reset();
        got_id.delete();
        set_req(0, 4'd2, 4'd3);
        set_req(1, 4'hE, 4'd5);
        run_cycle();
        run_cycle();
        resp_ready = 1'b0;
        set_req(2, 4'd6, 4'hA);
        repeat (5) run_cycle();
        resp_ready = 1'b1;
        drain();
        chk("bp_count", 32'(got_id.size()), 32'(3));
        for (int k = 0; k < 3 && k < got_id.size(); k++)
            chk("bp_order", 32'(got_id[k]), 32'(k));

        // Reset with S1 and S2 full
        for (int k = 0; k < 3; k++) begin
            rearm_all(k);
            run_cycle();
        end
        do_reset();
        req_valid = '0;
        got_p.delete();
        repeat (3) run_cycle();
        chk("no_stale_resp", 32'(got_p.size()), 32'(0));
        grant_log.delete();
        set_req(3, 4'd1, 4'd1);
        set_req(0, 4'd2, 4'd2);
        drain();
        chk("post_reset_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'(0));

        // Sparse requests from pointer 3; idle cycles leave the pointer alone
        set_req(2, 4'd4, 4'd4);
        run_cycle();
        repeat (4) run_cycle();
        grant_log.delete();
        set_req(0, 4'd3, 4'hD);
        set_req(2, 4'hC, 4'd2);
        drain();
        chk("sparse_count", 32'(grant_log.size()), 32'(2));
        if (grant_log.size() == 2) begin
            chk("sparse_first", 32'(grant_log[0]), 32'(0));
            chk("sparse_second", 32'(grant_log[1]), 32'(2));
        end

        // Randomized traffic and backpressure
        for (int c = 0; c < 2000; c++) begin
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++)
                if (!req_valid[2'(i)] && $urandom_range(0, 2) == 0)
                    set_req(i, 4'($urandom), 4'($urandom));
            run_cycle();
        end
        resp_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
